// File: rtl/ch_req_scheduler.sv
// ch_req_scheduler
//   Collects per-channel request pulses into a pending mask and drives that mask to the channel
//   encoder. It captures the encoder's one-hot pick as a held grant with a valid/ready handshake.
//   The served channel is retired on handshake, and requests lost to overflow are flagged.
//
// Ports:
//   clk_i          - clock, rising edge
//   resetn_i       - asynchronous active-low reset
//   req_i          - per-channel request pulses, OR-ed into the pending mask
//   ch_sel_o       - registered pending mask, feeds encoder ch_sel_i
//   enc_hot_one_i  - encoder one-hot pick
//   enc_valid_i    - encoder pick valid
//   gnt_valid_o    - grant offered downstream
//   gnt_ready_i    - downstream accepts grant
//   gnt_onehot_o   - granted channel, one-hot
//   gnt_idx_o      - granted channel, binary index
//   ovf_o          - sticky per-channel overflow (request hit an already pending channel)
//   ovf_clr_i      - clears ovf_o; a same-cycle new event for a bit wins
//   err_o          - sticky: encoder returned an illegal pick
//   pending_cnt_o  - popcount of ch_sel_o
module ch_req_scheduler #(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned IDX_W = $clog2(N_CH)
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [N_CH-1:0]  req_i,
    output logic [N_CH-1:0]  ch_sel_o,
    input  logic [N_CH-1:0]  enc_hot_one_i,
    input  logic             enc_valid_i,
    output logic             gnt_valid_o,
    input  logic             gnt_ready_i,
    output logic [N_CH-1:0]  gnt_onehot_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic [N_CH-1:0]  ovf_o,
    input  logic             ovf_clr_i,
    output logic             err_o,
    output logic [IDX_W:0]   pending_cnt_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [N_CH-1:0]  onehot_q, onehot_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N_CH-1:0]  served;
    logic [N_CH-1:0]  ovf_evt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_legal;

    // Pending mask, overflow and popcount
    always_comb begin
        served  = (state_q == StGrant && gnt_ready_i) ? onehot_q : '0;
        // A request landing on the retire cycle re-arms the bit instead of overflowing.
        pend_d  = (pend_q & ~served) | req_i;
        ovf_evt = req_i & pend_q & ~served;
        ovf_d   = ovf_clr_i ? ovf_evt : (ovf_q | ovf_evt);
        cnt_d   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            cnt_d = cnt_d + (IDX_W + 1)'(pend_d[k]);
        end
    end

    // Pick decode: exactly one bit set, and that bit must be pending
    always_comb begin
        pick_idx = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (enc_hot_one_i[k]) begin
                pick_idx = IDX_W'(k);
            end
        end
        pick_legal = (enc_hot_one_i != '0)
                   && ((enc_hot_one_i & (enc_hot_one_i - N_CH'(1))) == '0)
                   && ((enc_hot_one_i & ~pend_q) == '0);
    end

    // Grant FSM next state
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (enc_valid_i) begin
                    if (pick_legal) begin
                        onehot_d = enc_hot_one_i;
                        idx_d    = pick_idx;
                        state_d  = StGrant;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGrant: begin
                if (gnt_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= StIdle;
            pend_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= '0;
            err_q    <= 1'b0;
            onehot_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
        end
    end

    assign ch_sel_o      = pend_q;
    assign pending_cnt_o = cnt_q;
    assign ovf_o         = ovf_q;
    assign err_o         = err_q;
    assign gnt_valid_o   = (state_q == StGrant);
    assign gnt_onehot_o  = onehot_q;
    assign gnt_idx_o     = idx_q;

endmodule
